npu_op_scheduler: RTL and testbench

NPU_OP_SCHEDULER -- requirements
Module: npu_op_scheduler

---
 rtl/npu_pkg.sv | 25 ++
 rtl/npu_op_scheduler.sv | 170 +++++++++++++++++
 tb/tb_npu_op_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared encodings for the NPU operation scheduler: opcodes, operation_signal_in
// codes and the scheduler state type.
package npu_pkg;

    localparam logic [1:0] OP_OS_OP   = 2'b01;
    localparam logic [1:0] OP_OUT2ACT = 2'b10;

    localparam logic [2:0] OPSIG_IDLE    = 3'b000;
    localparam logic [2:0] OPSIG_CLEAR   = 3'b100;
    localparam logic [2:0] OPSIG_COMPUTE = 3'b001;
    localparam logic [2:0] OPSIG_DRAIN   = 3'b010;
    localparam logic [2:0] OPSIG_OUTPUT  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CLEAR       = 3'd1,
        ST_COMPUTE     = 3'd2,
        ST_DRAIN       = 3'd3,
        ST_WB          = 3'd4,
        ST_INTRA_START = 3'd5,
        ST_INTRA_WAIT  = 3'd6,
        ST_DONE        = 3'd7
    } state_t;

endpackage

// File: rtl/npu_op_scheduler.sv
// Command-driven FSM sequencing systolic-array phases (OS_OP) and intra-net transfers (OUT2ACT).
// Optional INTRA_WAIT watchdog enabled by defining NPU_SCHED_WDOG_EN.
module npu_op_scheduler
    import npu_pkg::*;
#(
    parameter int ARRAY_N     = 4,
    parameter int ARRAY_M     = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [31:0]           cmd_k_i,
    input  logic [ADDR_WIDTH-1:0] cmd_a_base_i,
    input  logic [ADDR_WIDTH-1:0] cmd_w_base_i,
    input  logic [ADDR_WIDTH-1:0] cmd_o_base_i,
    output logic                  a_buf_on,
    output logic                  w_buf_on,
    output logic                  o_ag_o_on,
    output logic                  Intranet_on,
    output logic                  Intra_sig_start,
    output logic [ADDR_WIDTH-1:0] a_base_addr,
    output logic [ADDR_WIDTH-1:0] w_base_addr,
    output logic [ADDR_WIDTH-1:0] o_base_addr,
    output logic [2:0]            operation_signal_in,
    input  logic                  Intra_sig_end,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [31:0] DRAIN_LEN = 32'(ARRAY_M + ARRAY_N - 2);
    localparam logic [31:0] WB_LEN    = 32'(ARRAY_M);

    if (ARRAY_M < 1 || ARRAY_N < 1 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("npu_op_scheduler: ARRAY_M, ARRAY_N and WDOG_CYCLES must be at least 1");
    end

    state_t                state_reg, state_next;
    logic [31:0]           cnt_reg;
    logic [31:0]           k_reg;
    logic [1:0]            op_reg;
    logic [ADDR_WIDTH-1:0] a_base_reg, w_base_reg, o_base_reg;
    logic                  err_reg, err_next;
    logic                  accept;

    assign accept      = cmd_valid_i && (state_reg == ST_IDLE);
    assign a_base_addr = a_base_reg;
    assign w_base_addr = w_base_reg;
    assign o_base_addr = o_base_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            k_reg      <= '0;
            op_reg     <= '0;
            a_base_reg <= '0;
            w_base_reg <= '0;
            o_base_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            // Phase counter restarts on every state entry and saturates rather than wrapping.
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != '1) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
            if (accept) begin
                op_reg     <= cmd_op_i;
                k_reg      <= cmd_k_i;
                a_base_reg <= cmd_a_base_i;
                w_base_reg <= cmd_w_base_i;
                o_base_reg <= cmd_o_base_i;
            end
        end
    end

    always_comb begin
        state_next          = state_reg;
        err_next            = 1'b0;
        cmd_ready_o         = 1'b0;
        busy_o              = 1'b1;
        a_buf_on            = 1'b0;
        w_buf_on            = 1'b0;
        o_ag_o_on           = 1'b0;
        Intranet_on         = 1'b0;
        Intra_sig_start     = 1'b0;
        operation_signal_in = OPSIG_IDLE;
        done_o              = 1'b0;
        err_o               = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        OP_OS_OP:   state_next = ST_CLEAR;
                        OP_OUT2ACT: state_next = ST_INTRA_START;
                        default: begin
                            state_next = ST_DONE;
                            err_next   = 1'b1;
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                operation_signal_in = OPSIG_CLEAR;
                // An empty reduction has nothing to compute and is reported as an error.
                if (op_reg != OP_OS_OP || k_reg == 32'd0) begin
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                end else begin
                    state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                operation_signal_in = OPSIG_COMPUTE;
                a_buf_on            = 1'b1;
                w_buf_on            = 1'b1;
                if (cnt_reg == k_reg - 32'd1) begin
                    state_next = (DRAIN_LEN == 32'd0) ? ST_WB : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                operation_signal_in = OPSIG_DRAIN;
                if (cnt_reg == DRAIN_LEN - 32'd1) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                operation_signal_in = OPSIG_OUTPUT;
                o_ag_o_on           = 1'b1;
                if (cnt_reg == WB_LEN - 32'd1) begin
                    state_next = ST_DONE;
                end
            end
            ST_INTRA_START: begin
                Intranet_on     = 1'b1;
                Intra_sig_start = 1'b1;
                state_next      = ST_INTRA_WAIT;
            end
            ST_INTRA_WAIT: begin
                Intranet_on = 1'b1;
                if (Intra_sig_end) begin
                    state_next = ST_DONE;
                end
`ifdef NPU_SCHED_WDOG_EN
                else if (cnt_reg == 32'(WDOG_CYCLES - 1)) begin
                    state_next = ST_DONE;
                    err_next   = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                done_o     = 1'b1;
                err_o      = err_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_npu_op_scheduler.sv
// Self-checking bench for npu_op_scheduler: directed scenarios plus random commands,
// compared every cycle against a per-command phase plan built from the phase-length rules.
module tb_npu_op_scheduler;

    localparam int N  = 4;
    localparam int M  = 4;
    localparam int AW = 32;
    localparam int WD = 16;
`ifdef NPU_SCHED_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int S_IDLE     = 0;
    localparam int S_CLEAR    = 1;
    localparam int S_COMPUTE  = 2;
    localparam int S_DRAIN    = 3;
    localparam int S_WB       = 4;
    localparam int S_ISTART   = 5;
    localparam int S_IWAIT    = 6;
    localparam int S_DONE     = 7;
    localparam int S_DONE_ERR = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i = '0;
    logic [31:0]   cmd_k_i = '0;
    logic [AW-1:0] cmd_a_base_i = '0, cmd_w_base_i = '0, cmd_o_base_i = '0;
    logic          a_buf_on, w_buf_on, o_ag_o_on, Intranet_on, Intra_sig_start;
    logic [AW-1:0] a_base_addr, w_base_addr, o_base_addr;
    logic [2:0]    operation_signal_in;
    logic          Intra_sig_end = 1'b0;
    logic          busy_o, done_o, err_o;
    logic [11:0]   obs_vec;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]    nx_op;
    logic [31:0]   nx_k;
    logic [AW-1:0] nx_a, nx_w, nx_o;

    always #5 clk = ~clk;

    npu_op_scheduler #(
        .ARRAY_N(N), .ARRAY_M(M), .ADDR_WIDTH(AW), .WDOG_CYCLES(WD)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_k_i(cmd_k_i),
        .cmd_a_base_i(cmd_a_base_i), .cmd_w_base_i(cmd_w_base_i), .cmd_o_base_i(cmd_o_base_i),
        .a_buf_on(a_buf_on), .w_buf_on(w_buf_on), .o_ag_o_on(o_ag_o_on),
        .Intranet_on(Intranet_on), .Intra_sig_start(Intra_sig_start),
        .a_base_addr(a_base_addr), .w_base_addr(w_base_addr), .o_base_addr(o_base_addr),
        .operation_signal_in(operation_signal_in), .Intra_sig_end(Intra_sig_end),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    assign obs_vec = {busy_o, cmd_ready_o, a_buf_on, w_buf_on, o_ag_o_on, Intranet_on,
                      Intra_sig_start, operation_signal_in, done_o, err_o};

    // Observable outputs for each phase: {busy, ready, a, w, o, intranet, start, opsig, done, err}
    function automatic logic [11:0] expect_of(input int s);
        logic       busy = 1'b1, rdy = 1'b0, a = 1'b0, w = 1'b0, o = 1'b0;
        logic       inet = 1'b0, st = 1'b0, dn = 1'b0, er = 1'b0;
        logic [2:0] sig = 3'b000;
        case (s)
            S_IDLE:     begin busy = 1'b0; rdy = 1'b1; end
            S_CLEAR:    sig = 3'b100;
            S_COMPUTE:  begin a = 1'b1; w = 1'b1; sig = 3'b001; end
            S_DRAIN:    sig = 3'b010;
            S_WB:       begin o = 1'b1; sig = 3'b011; end
            S_ISTART:   begin inet = 1'b1; st = 1'b1; end
            S_IWAIT:    inet = 1'b1;
            S_DONE:     dn = 1'b1;
            S_DONE_ERR: begin dn = 1'b1; er = 1'b1; end
            default:    busy = 1'bx;
        endcase
        return {busy, rdy, a, w, o, inet, st, sig, dn, er};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // d = cycle of INTRA_WAIT (1-based) in which Intra_sig_end is raised; 0 = never.
    // pre = command was already accepted by the previous edge; hold = keep cmd_valid_i high
    // and present nx_* as the following command.
    task automatic issue(input logic [1:0] op, input logic [31:0] k, input logic [AW-1:0] a,
                         input logic [AW-1:0] w, input logic [AW-1:0] o, input int d,
                         input bit pre, input bit hold);
        int plan[$];
        int wait_len;
        bit wd_err;
        wait_len = 0;
        wd_err   = 1'b0;
        if (!pre) begin
            cmd_op_i = op; cmd_k_i = k;
            cmd_a_base_i = a; cmd_w_base_i = w; cmd_o_base_i = o;
            cmd_valid_i = 1'b1;
            @(posedge clk); #1;
        end
        if (hold) begin
            cmd_op_i = nx_op; cmd_k_i = nx_k;
            cmd_a_base_i = nx_a; cmd_w_base_i = nx_w; cmd_o_base_i = nx_o;
        end else begin
            cmd_valid_i = 1'b0;
        end

        if (op == 2'b01) begin
            plan.push_back(S_CLEAR);
            if (k == 0) begin
                plan.push_back(S_DONE_ERR);
            end else begin
                repeat (k) plan.push_back(S_COMPUTE);
                repeat (M + N - 2) plan.push_back(S_DRAIN);
                repeat (M) plan.push_back(S_WB);
                plan.push_back(S_DONE);
            end
        end else if (op == 2'b10) begin
            plan.push_back(S_ISTART);
            if (WD_EN && (d == 0 || d > WD)) begin
                wait_len = WD;
                wd_err   = 1'b1;
            end else begin
                wait_len = d;
            end
            repeat (wait_len) plan.push_back(S_IWAIT);
            plan.push_back(wd_err ? S_DONE_ERR : S_DONE);
        end else begin
            plan.push_back(S_DONE_ERR);
        end
        plan.push_back(S_IDLE);

        foreach (plan[i]) begin
            @(negedge clk);
            check($sformatf("op%0d_k%0d_d%0d_cycle%0d", op, k, d, i + 1), obs_vec, expect_of(plan[i]));
            if (i == 0 || plan[i] == S_IDLE)
                check($sformatf("addr_op%0d_cycle%0d", op, i + 1),
                      {a_base_addr, w_base_addr, o_base_addr}, {a, w, o});
            if (plan[i] == S_IWAIT)
                Intra_sig_end = (!wd_err && i == wait_len);
            else if (plan[i] == S_ISTART)
                Intra_sig_end = 1'b1;
            else
                Intra_sig_end = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        Intra_sig_end = 1'b0;
    endtask

    initial begin
        bit pending;
        bit hold;
        logic [1:0]    op;
        logic [31:0]   k;
        logic [AW-1:0] a, w, o;
        int d;

        // Power-on reset
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("reset_outputs", obs_vec, expect_of(S_IDLE));
        check("reset_addr", {a_base_addr, w_base_addr, o_base_addr}, '0);
        @(posedge clk); #1;

        issue(2'b01, 32'd5, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 0, 1'b0, 1'b0);
        issue(2'b01, 32'd0, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC, 0, 1'b0, 1'b0);
        issue(2'b10, 32'd7, 32'h4444_0000, 32'h5555_0000, 32'h6666_0000, 10, 1'b0, 1'b0);

        // Reset in cycle 3 of COMPUTE, K=8
        cmd_op_i = 2'b01; cmd_k_i = 32'd8;
        cmd_a_base_i = 32'hDEAD_0001; cmd_w_base_i = 32'hDEAD_0002; cmd_o_base_i = 32'hDEAD_0003;
        cmd_valid_i = 1'b1;
        @(posedge clk); #1 cmd_valid_i = 1'b0;
        @(negedge clk);
        check("midrst_clear", obs_vec, expect_of(S_CLEAR));
        repeat (3) @(negedge clk);
        check("midrst_compute3", obs_vec, expect_of(S_COMPUTE));
        rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        check("midrst_outputs", obs_vec, expect_of(S_IDLE));
        check("midrst_addr", {a_base_addr, w_base_addr, o_base_addr}, '0);
        repeat (20) begin
            @(negedge clk);
            check("midrst_no_done", obs_vec, expect_of(S_IDLE));
        end
        @(posedge clk); #1;
        issue(2'b01, 32'd3, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 0, 1'b0, 1'b0);

        // Back-to-back with cmd_valid_i held high; second command is illegal 2'b11
        nx_op = 2'b11; nx_k = 32'd9; nx_a = 32'h0BAD_0001; nx_w = 32'h0BAD_0002; nx_o = 32'h0BAD_0003;
        issue(2'b01, 32'd2, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 0, 1'b0, 1'b1);
        issue(nx_op, nx_k, nx_a, nx_w, nx_o, 0, 1'b1, 1'b0);
        issue(2'b00, 32'd4, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 0, 1'b0, 1'b0);

        // End pulse never arrives within the watchdog window (late pulse without the watchdog)
        issue(2'b10, 32'd0, 32'h7000_0000, 32'h7100_0000, 32'h7200_0000, WD_EN ? 0 : 25, 1'b0, 1'b0);

        // Random commands, sometimes issued back-to-back
        pending = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (pending) begin
                op = nx_op; k = nx_k; a = nx_a; w = nx_w; o = nx_o;
            end else begin
                op = 2'($urandom_range(0, 3));
                k  = 32'($urandom_range(0, 12));
                a  = $urandom; w = $urandom; o = $urandom;
            end
            d    = WD_EN ? $urandom_range(0, 24) : $urandom_range(1, 24);
            hold = ($urandom_range(0, 3) == 0);
            if (hold) begin
                nx_op = 2'($urandom_range(0, 3));
                nx_k  = 32'($urandom_range(0, 12));
                nx_a  = $urandom; nx_w = $urandom; nx_o = $urandom;
            end
            issue(op, k, a, w, o, d, pending, hold);
            pending = hold;
        end
        if (pending)
            issue(nx_op, nx_k, nx_a, nx_w, nx_o, 5, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
